// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill engine and write-port arbiter for the 80x60 framebuffer.
// CPU pixel writes always win the port; the engine stalls one cycle per collision.
module vga_fill_ctrl #(
  parameter logic [31:0] BASE_AD = 32'h11180000,
  parameter int          FB_W    = 80,
  parameter int          FB_H    = 60
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  input  logic [12:0] CPU_WA,
  input  logic [7:0]  CPU_WD,
  input  logic        CPU_WE,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  output logic [31:0] STATUS_RD,
  output logic        BUSY,
  output logic        DONE_INT
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [7:0] FB_W_LIM = 8'(FB_W);
  localparam logic [6:0] FB_H_LIM = 7'(FB_H);

  state_t     state;
  logic [6:0] pos_x, size_w, s_x0, s_w, cx;
  logic [5:0] pos_y, size_h, s_y0, s_h, cy;
  logic [7:0] color, s_color;
  logic       start_ignored;

  logic       pos_wr, size_wr, color_wr, ctrl_wr;
  logic [7:0] px;
  logic [6:0] py;
  logic       pix_in, last_col, last_row;
  logic       unused_bus_bits;

  assign pos_wr   = IOBUS_WR && (IOBUS_ADDR == BASE_AD);
  assign size_wr  = IOBUS_WR && (IOBUS_ADDR == BASE_AD + 32'h4);
  assign color_wr = IOBUS_WR && (IOBUS_ADDR == BASE_AD + 32'h8);
  assign ctrl_wr  = IOBUS_WR && (IOBUS_ADDR == BASE_AD + 32'hC);

  // Sums are one bit wider than the fields so off-screen pixels clip instead of wrapping.
  assign px       = {1'b0, s_x0} + {1'b0, cx};
  assign py       = {1'b0, s_y0} + {1'b0, cy};
  assign pix_in   = (px < FB_W_LIM) && (py < FB_H_LIM);
  assign last_col = (cx == s_w - 7'd1);
  assign last_row = (cy == s_h - 6'd1);

  assign BUSY      = (state != IDLE);
  assign STATUS_RD = {30'd0, start_ignored, BUSY};

  assign unused_bus_bits = ^IOBUS_OUT[30:14];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      pos_x         <= '0;
      pos_y         <= '0;
      size_w        <= '0;
      size_h        <= '0;
      color         <= '0;
      s_x0          <= '0;
      s_y0          <= '0;
      s_w           <= '0;
      s_h           <= '0;
      s_color       <= '0;
      cx            <= '0;
      cy            <= '0;
      start_ignored <= 1'b0;
      FB_WA         <= '0;
      FB_WD         <= '0;
      FB_WE         <= 1'b0;
      DONE_INT      <= 1'b0;
    end else begin
      if (pos_wr) begin
        pos_x <= IOBUS_OUT[6:0];
        pos_y <= IOBUS_OUT[13:8];
      end
      if (size_wr) begin
        size_w <= IOBUS_OUT[6:0];
        size_h <= IOBUS_OUT[13:8];
      end
      if (color_wr) color <= IOBUS_OUT[7:0];

      // A START that arrives while busy is remembered rather than queued.
      if (ctrl_wr) begin
        if (state != IDLE)       start_ignored <= 1'b1;
        else if (IOBUS_OUT[31])  start_ignored <= 1'b0;
      end

      FB_WE    <= 1'b0;
      DONE_INT <= 1'b0;
      if (CPU_WE) begin
        FB_WE <= 1'b1;
        FB_WA <= CPU_WA;
        FB_WD <= CPU_WD;
      end

      case (state)
        IDLE: begin
          if (ctrl_wr) begin
            s_x0    <= pos_x;
            s_y0    <= pos_y;
            s_w     <= size_w;
            s_h     <= size_h;
            s_color <= color;
            cx      <= '0;
            cy      <= '0;
            if (size_w == '0 || size_h == '0) begin
              state    <= DONE;
              DONE_INT <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (!CPU_WE) begin
            if (pix_in) begin
              FB_WE <= 1'b1;
              FB_WA <= {py[5:0], px[6:0]};
              FB_WD <= s_color;
            end
            if (last_col) begin
              cx <= '0;
              cy <= cy + 6'd1;
              if (last_row) begin
                state    <= DONE;
                DONE_INT <= 1'b1;
              end
            end else begin
              cx <= cx + 7'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Directed bench for vga_fill_ctrl: fills, CPU collisions, clipping, busy starts and reset.
module tb_vga_fill_ctrl;

  localparam logic [31:0] BASE = 32'h11180000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT;
  logic        IOBUS_WR;
  logic [12:0] CPU_WA;
  logic [7:0]  CPU_WD;
  logic        CPU_WE;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic        FB_WE;
  logic [31:0] STATUS_RD;
  logic        BUSY, DONE_INT;

  int checks = 0;
  int errors = 0;

  logic [12:0] cap_wa[$];
  logic [7:0]  cap_wd[$];
  int          cap_k[$];
  int          done_k[$];
  int          busy_last;

  vga_fill_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .CPU_WA(CPU_WA), .CPU_WD(CPU_WD), .CPU_WE(CPU_WE),
    .FB_WA(FB_WA), .FB_WD(FB_WD), .FB_WE(FB_WE),
    .STATUS_RD(STATUS_RD), .BUSY(BUSY), .DONE_INT(DONE_INT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic setup_fill(input int x0, input int y0, input int w, input int h, input int col);
    bus_write(BASE + 32'h0, 32'((y0 << 8) | x0));
    bus_write(BASE + 32'h4, 32'((h << 8) | w));
    bus_write(BASE + 32'h8, 32'(col));
  endtask

  task automatic sample(input int k);
    if (FB_WE === 1'b1) begin
      cap_wa.push_back(FB_WA);
      cap_wd.push_back(FB_WD);
      cap_k.push_back(k);
    end
    if (DONE_INT === 1'b1) done_k.push_back(k);
    if (BUSY === 1'b1) busy_last = k;
  endtask

  // k counts edges after the START edge; stimulus for step k is applied before edge k.
  task automatic capture(input int max_k, input int cpu_k, input int colw_k, input int ctrlw_k);
    cap_wa.delete(); cap_wd.delete(); cap_k.delete(); done_k.delete();
    busy_last = -1;
    sample(0);
    for (int k = 1; k <= max_k; k++) begin
      CPU_WE   = (k == cpu_k);
      CPU_WA   = 13'h0100;
      CPU_WD   = 8'h1C;
      IOBUS_WR = 1'b0;
      if (k == colw_k) begin
        IOBUS_ADDR = BASE + 32'h8; IOBUS_OUT = 32'h03; IOBUS_WR = 1'b1;
      end else if (k == ctrlw_k) begin
        IOBUS_ADDR = BASE + 32'hC; IOBUS_OUT = 32'h0; IOBUS_WR = 1'b1;
      end
      tick();
      sample(k);
    end
    CPU_WE   = 1'b0;
    IOBUS_WR = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
    CPU_WA = '0; CPU_WD = '0; CPU_WE = 1'b0;
    tick(); tick();
    checks++;
    if ({FB_WA, FB_WD, FB_WE, DONE_INT, BUSY} !== 24'd0 || STATUS_RD !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got wa=%h wd=%h we=%b done=%b busy=%b st=%h want all zero",
               FB_WA, FB_WD, FB_WE, DONE_INT, BUSY, STATUS_RD);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_cpu_path();
    CPU_WE = 1'b1; CPU_WA = 13'h1ABC; CPU_WD = 8'hA5;
    tick();
    CPU_WE = 1'b0;
    checks++;
    if (FB_WE !== 1'b1 || FB_WA !== 13'h1ABC || FB_WD !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_pass got we=%b wa=%h wd=%h want we=1 wa=1abc wd=a5", FB_WE, FB_WA, FB_WD);
    end
    tick();
    checks++;
    if (FB_WE !== 1'b0) begin
      errors++;
      $display("FAIL cpu_idle_we got %b want 0", FB_WE);
    end
  endtask

  task automatic test_basic_fill();
    int exp_a[6] = '{386, 387, 388, 514, 515, 516};
    setup_fill(2, 3, 3, 2, 8'hE0);
    bus_write(BASE + 32'hC, 32'h0);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_start got %b want 1", BUSY);
    end
    capture(10, 0, 0, 0);
    checks++;
    if (cap_wa.size() != 6) begin
      errors++;
      $display("FAIL basic_count got %0d want 6", cap_wa.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= cap_wa.size() || cap_wa[i] !== 13'(exp_a[i]) || cap_wd[i] !== 8'hE0 || cap_k[i] != i + 1) begin
        errors++;
        $display("FAIL basic_px%0d got wa=%0d wd=%h k=%0d want wa=%0d wd=e0 k=%0d",
                 i, cap_wa[i], cap_wd[i], cap_k[i], exp_a[i], i + 1);
      end
    end
    checks++;
    if (done_k.size() != 1 || done_k[0] != 6 || busy_last != 6) begin
      errors++;
      $display("FAIL basic_done got n=%0d k=%0d busy_last=%0d want n=1 k=6 busy_last=6",
               done_k.size(), done_k[0], busy_last);
    end
  endtask

  task automatic test_cpu_collision();
    int exp_a[7] = '{386, 256, 387, 388, 514, 515, 516};
    logic [7:0] exp_d[7] = '{8'hE0, 8'h1C, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
    bus_write(BASE + 32'hC, 32'h0);
    capture(10, 2, 0, 0);
    checks++;
    if (cap_wa.size() != 7) begin
      errors++;
      $display("FAIL coll_count got %0d want 7", cap_wa.size());
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= cap_wa.size() || cap_wa[i] !== 13'(exp_a[i]) || cap_wd[i] !== exp_d[i] || cap_k[i] != i + 1) begin
        errors++;
        $display("FAIL coll_px%0d got wa=%0d wd=%h k=%0d want wa=%0d wd=%h k=%0d",
                 i, cap_wa[i], cap_wd[i], cap_k[i], exp_a[i], exp_d[i], i + 1);
      end
    end
    checks++;
    if (done_k.size() != 1 || done_k[0] != 7) begin
      errors++;
      $display("FAIL coll_done got n=%0d k=%0d want n=1 k=7", done_k.size(), done_k[0]);
    end
  endtask

  task automatic test_clipping();
    setup_fill(78, 59, 4, 2, 8'h5A);
    bus_write(BASE + 32'hC, 32'h0);
    capture(12, 0, 0, 0);
    checks++;
    if (cap_wa.size() != 2 || cap_wa[0] !== 13'd7630 || cap_wa[1] !== 13'd7631 ||
        cap_wd[0] !== 8'h5A || cap_k[0] != 1 || cap_k[1] != 2) begin
      errors++;
      $display("FAIL clip_writes got n=%0d wa0=%0d wa1=%0d want n=2 wa0=7630 wa1=7631",
               cap_wa.size(), cap_wa[0], cap_wa[1]);
    end
    checks++;
    if (busy_last != 8 || done_k.size() != 1 || done_k[0] != 8) begin
      errors++;
      $display("FAIL clip_busy got busy_last=%0d done_k=%0d want 8 and 8", busy_last, done_k[0]);
    end
  endtask

  task automatic test_zero_size();
    setup_fill(5, 5, 0, 5, 8'hFF);
    bus_write(BASE + 32'hC, 32'h0);
    capture(4, 0, 0, 0);
    checks++;
    if (cap_wa.size() != 0) begin
      errors++;
      $display("FAIL zero_writes got %0d want 0", cap_wa.size());
    end
    checks++;
    if (done_k.size() != 1 || done_k[0] != 0 || busy_last != 0) begin
      errors++;
      $display("FAIL zero_done got n=%0d k=%0d busy_last=%0d want n=1 k=0 busy_last=0",
               done_k.size(), done_k[0], busy_last);
    end
  endtask

  task automatic test_start_busy();
    setup_fill(10, 5, 4, 1, 8'h11);
    bus_write(BASE + 32'hC, 32'h0);
    capture(8, 0, 2, 3);
    checks++;
    if (cap_wa.size() != 4 || cap_wd[0] !== 8'h11 || cap_wd[3] !== 8'h11 ||
        cap_wa[0] !== 13'd650 || cap_wa[3] !== 13'd653 || done_k.size() != 1 || done_k[0] != 4) begin
      errors++;
      $display("FAIL busy_old_fill got n=%0d wd0=%h wd3=%h wa0=%0d done_k=%0d want n=4 wd=11 wa0=650 done_k=4",
               cap_wa.size(), cap_wd[0], cap_wd[3], cap_wa[0], done_k[0]);
    end
    checks++;
    if (STATUS_RD !== 32'h2) begin
      errors++;
      $display("FAIL busy_status got %h want 00000002", STATUS_RD);
    end
    bus_write(BASE + 32'hC, 32'h8000_0000);
    capture(8, 0, 0, 0);
    checks++;
    if (cap_wa.size() != 4 || cap_wd[0] !== 8'h03 || cap_wd[3] !== 8'h03 || cap_wa[3] !== 13'd653) begin
      errors++;
      $display("FAIL busy_new_fill got n=%0d wd0=%h wd3=%h wa3=%0d want n=4 wd=03 wa3=653",
               cap_wa.size(), cap_wd[0], cap_wd[3], cap_wa[3]);
    end
    checks++;
    if (STATUS_RD !== 32'h0) begin
      errors++;
      $display("FAIL busy_status_clr got %h want 00000000", STATUS_RD);
    end
  endtask

  task automatic test_reset_mid_fill();
    int stray = 0;
    setup_fill(2, 3, 3, 2, 8'hE0);
    bus_write(BASE + 32'hC, 32'h0);
    tick(); tick(); tick();
    checks++;
    if (FB_WE !== 1'b1 || FB_WA !== 13'd388) begin
      errors++;
      $display("FAIL rst_third_px got we=%b wa=%0d want we=1 wa=388", FB_WE, FB_WA);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (FB_WE !== 1'b0 || BUSY !== 1'b0 || DONE_INT !== 1'b0 || FB_WA !== 13'd0 || STATUS_RD !== 32'd0) begin
      errors++;
      $display("FAIL rst_async got we=%b busy=%b done=%b wa=%0d st=%h want all zero",
               FB_WE, BUSY, DONE_INT, FB_WA, STATUS_RD);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (FB_WE !== 1'b0 || BUSY !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_quiet got %0d active cycles want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_path();
    test_basic_fill();
    test_cpu_collision();
    test_clipping();
    test_zero_size();
    test_start_busy();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
